acc_sched: RTL and testbench

ACC_SCHED -- requirements
Module: acc_sched

---
 rtl/acc_sched.sv | 140 ++++++++++++++
 tb/tb_acc_sched.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/acc_sched.sv
// Job scheduler for the accumulator. It holds a small FIFO of (iters, reads) jobs,
// configures the accumulator for each job in turn and counts output beats until the job completes.
module acc_sched #(
   parameter int unsigned LOG_MAX_ITERS          = 16,
   parameter int unsigned LOG_MAX_READS_PER_ITER = 12,
   parameter int unsigned NUM_JOBS               = 4,
   parameter int unsigned LOG_NUM_JOBS           = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              job_valid,
   input  logic [LOG_MAX_ITERS-1:0]          job_iters,
   input  logic [LOG_MAX_READS_PER_ITER-1:0] job_reads,
   output logic                              job_ready,
   input  logic                              abort,
   output logic                              acc_configure,
   output logic [LOG_MAX_ITERS-1:0]          acc_num_iters,
   output logic [LOG_MAX_READS_PER_ITER-1:0] acc_num_reads_per_iter,
   input  logic                              acc_valid_out,
   output logic                              acc_in_enable,
   output logic                              busy,
   output logic                              job_done,
   output logic                              job_error,
   output logic [15:0]                       jobs_done_count
);

   localparam int unsigned IW = LOG_MAX_ITERS;
   localparam int unsigned RW = LOG_MAX_READS_PER_ITER;
   localparam int unsigned PW = LOG_NUM_JOBS;
   localparam int unsigned CW = LOG_NUM_JOBS + 1;
   localparam logic [CW-1:0] FULL = CW'(NUM_JOBS);

   typedef enum logic [1:0] {IDLE, CONFIG, RUN, DONE} state_t;

   state_t         state, state_nxt;
   logic [IW-1:0]  q_iters [NUM_JOBS];
   logic [RW-1:0]  q_reads [NUM_JOBS];
   logic [PW-1:0]  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic [CW-1:0]  count, count_nxt;
   logic [RW-1:0]  beat_cnt, beat_nxt;
   logic [15:0]    done_cnt_nxt;
   logic           space_c, zero_c, push_c, err_c, pop_c;

   // Next-state, queue bookkeeping and beat counting; abort overrides everything
   always_comb begin
      space_c      = (count != FULL);
      zero_c       = (job_iters == '0) || (job_reads == '0);
      push_c       = job_valid && space_c && !zero_c && !abort;
      err_c        = job_valid && space_c && zero_c && !abort;
      pop_c        = (state == IDLE) && (count != '0) && !abort;
      state_nxt    = state;
      beat_nxt     = beat_cnt;
      done_cnt_nxt = jobs_done_count;
      wr_ptr_nxt   = push_c ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr_nxt   = pop_c  ? rd_ptr + PW'(1) : rd_ptr;
      count_nxt    = count;

      case (state)
         IDLE: begin
            if (pop_c) begin
               state_nxt = CONFIG;
               beat_nxt  = q_reads[rd_ptr];
            end
         end
         CONFIG: state_nxt = RUN;
         RUN: begin
            if (acc_valid_out) begin
               beat_nxt = beat_cnt - RW'(1);
               if (beat_cnt == RW'(1)) begin
                  state_nxt    = DONE;
                  done_cnt_nxt = jobs_done_count + 16'd1;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      case ({push_c, pop_c})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase

      if (abort) begin
         state_nxt    = IDLE;
         beat_nxt     = beat_cnt;
         done_cnt_nxt = jobs_done_count;
         count_nxt    = '0;
         wr_ptr_nxt   = '0;
         rd_ptr_nxt   = '0;
      end
   end

   // State, pointers and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                  <= IDLE;
         wr_ptr                 <= '0;
         rd_ptr                 <= '0;
         count                  <= '0;
         beat_cnt               <= '0;
         job_ready              <= 1'b1;
         busy                   <= 1'b0;
         acc_configure          <= 1'b0;
         acc_in_enable          <= 1'b0;
         job_done               <= 1'b0;
         job_error              <= 1'b0;
         jobs_done_count        <= '0;
         acc_num_iters          <= '0;
         acc_num_reads_per_iter <= '0;
      end else begin
         state           <= state_nxt;
         wr_ptr          <= wr_ptr_nxt;
         rd_ptr          <= rd_ptr_nxt;
         count           <= count_nxt;
         beat_cnt        <= beat_nxt;
         job_ready       <= (count_nxt != FULL);
         busy            <= (state_nxt != IDLE) || (count_nxt != '0);
         acc_configure   <= (state_nxt == CONFIG);
         acc_in_enable   <= (state_nxt == RUN);
         job_done        <= (state_nxt == DONE);
         job_error       <= err_c;
         jobs_done_count <= done_cnt_nxt;
         if (pop_c) begin
            acc_num_iters          <= q_iters[rd_ptr];
            acc_num_reads_per_iter <= q_reads[rd_ptr];
         end
      end
   end

   // Job storage; emptiness is tracked by count, so the entries need no reset
   always_ff @(posedge clk) begin
      if (push_c) begin
         q_iters[wr_ptr] <= job_iters;
         q_reads[wr_ptr] <= job_reads;
      end
   end

endmodule

// File: tb/tb_acc_sched.sv
// Randomized and directed bench for acc_sched, checked every cycle against a queue-based job model.
module tb_acc_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        job_valid;
   logic [15:0] job_iters;
   logic [11:0] job_reads;
   logic        job_ready;
   logic        abort;
   logic        acc_configure;
   logic [15:0] acc_num_iters;
   logic [11:0] acc_num_reads_per_iter;
   logic        acc_valid_out;
   logic        acc_in_enable;
   logic        busy;
   logic        job_done;
   logic        job_error;
   logic [15:0] jobs_done_count;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   acc_sched dut (
      .clk(clk), .rst(rst),
      .job_valid(job_valid), .job_iters(job_iters), .job_reads(job_reads), .job_ready(job_ready),
      .abort(abort), .acc_configure(acc_configure), .acc_num_iters(acc_num_iters),
      .acc_num_reads_per_iter(acc_num_reads_per_iter), .acc_valid_out(acc_valid_out),
      .acc_in_enable(acc_in_enable), .busy(busy), .job_done(job_done), .job_error(job_error),
      .jobs_done_count(jobs_done_count)
   );

   // Reference model: job list plus a phase (0 idle, 1 configure, 2 run, 3 done)
   int m_q_it[$];
   int m_q_rd[$];
   int m_phase, m_beats, m_iters, m_reads, m_done_cnt;
   bit m_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q_it.delete(); m_q_rd.delete();
      m_phase = 0; m_beats = 0; m_iters = 0; m_reads = 0; m_done_cnt = 0; m_err = 0;
   endtask

   task automatic model_step();
      bit acc, zero;
      if (rst) begin
         model_reset();
      end else if (abort) begin
         m_q_it.delete(); m_q_rd.delete();
         m_phase = 0; m_err = 0;
      end else begin
         acc   = job_valid && (m_q_it.size() < 4);
         zero  = (job_iters == 0) || (job_reads == 0);
         m_err = acc && zero;
         case (m_phase)
            0: if (m_q_it.size() > 0) begin
               m_iters = m_q_it.pop_front();
               m_reads = m_q_rd.pop_front();
               m_beats = m_reads;
               m_phase = 1;
            end
            1: m_phase = 2;
            2: if (acc_valid_out) begin
               m_beats--;
               if (m_beats == 0) begin
                  m_phase    = 3;
                  m_done_cnt = (m_done_cnt + 1) % 65536;
               end
            end
            default: m_phase = 0;
         endcase
         if (acc && !zero) begin
            m_q_it.push_back(int'(job_iters));
            m_q_rd.push_back(int'(job_reads));
         end
      end
   endtask

   task automatic check_all();
      chk("job_ready",     32'(job_ready),       32'(m_q_it.size() < 4));
      chk("busy",          32'(busy),            32'((m_phase != 0) || (m_q_it.size() > 0)));
      chk("acc_configure", 32'(acc_configure),   32'(m_phase == 1));
      chk("acc_in_enable", 32'(acc_in_enable),   32'(m_phase == 2));
      chk("job_done",      32'(job_done),        32'(m_phase == 3));
      chk("job_error",     32'(job_error),       32'(m_err));
      chk("done_count",    32'(jobs_done_count), 32'(m_done_cnt));
      chk("num_iters",     32'(acc_num_iters),   32'(m_iters));
      chk("num_reads",     32'(acc_num_reads_per_iter), 32'(m_reads));
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic drive(input bit v, input int it, input int rd, input bit avo, input bit ab);
      job_valid     = v;
      job_iters     = 16'(it);
      job_reads     = 12'(rd);
      acc_valid_out = avo;
      abort         = ab;
   endtask

   int cfg_seen, done_seen;

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      model_reset();
      #3;
      check_all();
      step();
      rst = 1'b0;
      step();

      // Single job 3/4 with four beats
      cfg_seen = 0; done_seen = 0;
      drive(1, 3, 4, 0, 0); step();
      drive(0, 0, 0, 0, 0); step();
      cfg_seen += int'(acc_configure);
      chk("cfg_iters", 32'(acc_num_iters), 32'd3);
      chk("cfg_reads", 32'(acc_num_reads_per_iter), 32'd4);
      step();
      chk("run_enable", 32'(acc_in_enable), 32'd1);
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 0, i < 4, 0); step();
         cfg_seen  += int'(acc_configure);
         done_seen += int'(job_done);
      end
      chk("cfg_pulses", 32'(cfg_seen), 32'd1);
      chk("done_pulses", 32'(done_seen), 32'd1);
      chk("done_count_1", 32'(jobs_done_count), 32'd1);

      // Zero-field job is dropped with an error pulse
      drive(1, 0, 5, 0, 0); step();
      chk("zero_err", 32'(job_error), 32'd1);
      chk("zero_busy", 32'(busy), 32'd0);
      drive(0, 0, 0, 0, 0); step();
      chk("zero_nocfg", 32'(acc_configure), 32'd0);

      // Back-to-back pushes until the queue fills, then extra pushes are ignored
      for (int i = 0; i < 7; i++) begin drive(1, i + 1, i + 2, 0, 0); step(); end
      chk("full_ready", 32'(job_ready), 32'd0);
      // Drain while holding a push across the done/idle pop cycles
      for (int i = 0; i < 60; i++) begin drive(1, 9, 2, 1, 0); step(); end
      drive(0, 0, 0, 1, 0);
      for (int i = 0; i < 40; i++) step();

      // Abort mid-run with two jobs queued
      drive(1, 2, 3, 0, 0); step(); step(); step();
      drive(0, 0, 0, 0, 0); step(); step();
      drive(0, 0, 0, 1, 0); step();
      drive(0, 0, 0, 0, 1); step();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_idle", 32'(acc_in_enable), 32'd0);
      drive(0, 0, 0, 1, 0);
      for (int i = 0; i < 6; i++) step();

      // Asynchronous reset mid-run, then a fresh job
      drive(1, 5, 3, 0, 0); step(); step(); step();
      drive(0, 0, 0, 1, 0); step();
      #2; rst = 1'b1; #1;
      model_reset();
      check_all();
      step();
      rst = 1'b0;
      drive(0, 0, 0, 1, 0); step(); step();
      chk("rst_no_cfg", 32'(acc_configure), 32'd0);
      drive(1, 4, 2, 1, 0); step();
      drive(0, 0, 0, 1, 0);
      for (int i = 0; i < 8; i++) step();

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         drive($urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 6),
               $urandom_range(0, 9) < 7, $urandom_range(0, 99) == 0);
         rst = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 1'b0;
      drive(0, 0, 0, 0, 0); step();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
